// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: groups the keypad-entry key stream and the operand,
// strobe and display outputs of keypad_entry_ctrl.
//
// Key stream protocol: key_valid is a level held by the scanner for as long
// as a key is down. There is no ready/backpressure signal. The controller
// treats each rising edge of key_valid as exactly one press and samples
// key_code only in that cycle. A new press requires key_valid to drop first.
//
// master: the key source (scanner side). It drives key_valid and key_code.
// slave : keypad_entry_ctrl. It drives the operands, the strobe and the
//         display/debug outputs.
interface keypad_entry_ctrl_if #(
    parameter int MAX_DIGITS = 3,
    parameter int DATA_W     = 10
);
    logic                               key_valid;
    logic [3:0]                         key_code;
    logic [DATA_W-1:0]                  op_a;
    logic [DATA_W-1:0]                  op_b;
    logic                               add_start;
    logic [4*MAX_DIGITS-1:0]            entry_bcd;
    logic [$clog2(MAX_DIGITS+1)-1:0]    entry_count;
    logic [2:0]                         state;

    modport master (
        output key_valid,
        output key_code,
        input  op_a,
        input  op_b,
        input  add_start,
        input  entry_bcd,
        input  entry_count,
        input  state
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output op_a,
        output op_b,
        output add_start,
        output entry_bcd,
        output entry_count,
        output state
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: turns the keypad scanner's decoded key stream into two
// binary operands for the adder.
//
// Entry runs in a fixed order: operand A, then operand B, then a one-cycle
// add_start strobe. Digits are collected into a BCD buffer of MAX_DIGITS
// digits. The buffer is converted to binary by a MAX_DIGITS-cycle
// multiply-by-ten loop, where each step computes acc*10 + digit.
//
// Optional feature macro: KEYPAD_BACKSPACE_EN. When it is defined, key 0xD
// deletes the most recent digit while an operand is being entered. When it is
// undefined, 0xD is just another ignored code.
//
// The FSM state is exported on bus.state:
// ENTRY_A=0, CONV_A=1, ENTRY_B=2, CONV_B=3, DONE=4.
module keypad_entry_ctrl #(
    parameter int MAX_DIGITS = 3,
    parameter int DATA_W     = 10
) (
    input logic                clk,
    input logic                rst,
    keypad_entry_ctrl_if.slave bus
);

    localparam int BW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
    localparam logic [IW-1:0] IDX_TOP = IW'(MAX_DIGITS - 1);

    localparam logic [3:0] KEY_NEXT  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
`ifdef KEYPAD_BACKSPACE_EN
    localparam logic [3:0] KEY_BACK  = 4'hD;
`endif

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        CONV_A  = 3'd1,
        ENTRY_B = 3'd2,
        CONV_B  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               key_prev_q;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d;
    logic [DATA_W-1:0]  op_b_q, op_b_d;
    logic               start_q, start_d;

    // A press is the rising edge of the key_valid level. Holding a key
    // down therefore counts once.
    logic press;
    logic key_digit;
    logic key_next;
    logic key_clear;
`ifdef KEYPAD_BACKSPACE_EN
    logic key_back;
`endif

    assign press     = bus.key_valid & ~key_prev_q;
    assign key_digit = press & (bus.key_code <= 4'd9);
    assign key_next  = press & (bus.key_code == KEY_NEXT);
    assign key_clear = press & (bus.key_code == KEY_CLEAR);
`ifdef KEYPAD_BACKSPACE_EN
    assign key_back  = press & (bus.key_code == KEY_BACK);
`endif

    // Select the digit being folded in this conversion cycle.
    // The loop walks from the most significant digit down to digit 0.
    logic [3:0] sel_digit;
    always_comb begin
        sel_digit = 4'd0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_digit = bcd_q[i*4 +: 4];
            end
        end
    end

    // One conversion step: acc*10 + digit, with *10 built as (acc<<3)+(acc<<1).
    // The result wraps modulo 2^DATA_W when 10^MAX_DIGITS-1 does not fit.
    logic [DATA_W-1:0] acc_step;
    assign acc_step = (acc_q << 3) + (acc_q << 1) + DATA_W'(sel_digit);

    // Next-state and datapath decode. Clear has priority in every state,
    // so it also cancels an in-flight conversion and any pending strobe.
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        start_d = 1'b0;

        if (key_clear) begin
            state_d = ENTRY_A;
            bcd_d   = '0;
            cnt_d   = '0;
            acc_d   = '0;
            idx_d   = '0;
            op_a_d  = '0;
            op_b_d  = '0;
        end else begin
            case (state_q)
                ENTRY_A, ENTRY_B: begin
                    if (key_digit) begin
                        // A digit beyond the buffer size is dropped.
                        if (cnt_q < CNT_MAX) begin
                            bcd_d = (bcd_q << 4) | BW'(bus.key_code);
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (key_next) begin
                        // An empty buffer converts to operand 0.
                        state_d = (state_q == ENTRY_A) ? CONV_A : CONV_B;
                        idx_d   = IDX_TOP;
                        acc_d   = '0;
`ifdef KEYPAD_BACKSPACE_EN
                    end else if (key_back) begin
                        if (cnt_q != '0) begin
                            bcd_d = bcd_q >> 4;
                            cnt_d = cnt_q - CW'(1);
                        end
`endif
                    end
                end

                CONV_A, CONV_B: begin
                    // Key presses other than clear are swallowed during conversion.
                    acc_d = acc_step;
                    if (idx_q == '0) begin
                        if (state_q == CONV_A) begin
                            op_a_d  = acc_step;
                            state_d = ENTRY_B;
                        end else begin
                            op_b_d  = acc_step;
                            state_d = DONE;
                            start_d = 1'b1;
                        end
                        bcd_d = '0;
                        cnt_d = '0;
                        acc_d = '0;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end

                DONE: begin
                    // A new digit starts the next calculation. The old operands
                    // stay visible until they are reconverted.
                    if (key_digit) begin
                        state_d = ENTRY_A;
                        bcd_d   = BW'(bus.key_code);
                        cnt_d   = CW'(1);
                    end
                end

                default: begin
                    state_d = ENTRY_A;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ENTRY_A;
            key_prev_q <= 1'b0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= bus.key_valid;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            start_q    <= start_d;
        end
    end

    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.add_start   = start_q;
    assign bus.entry_bcd   = bcd_q;
    assign bus.entry_count = cnt_q;
    assign bus.state       = state_q;

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Sequences operand entry for the adder from the matrix-keypad scanner's decoded key stream.
- Detects one press per key, collects up to MAX_DIGITS decimal digits per operand into a BCD buffer, and converts the buffer to binary with a multi-cycle shift-add loop.
- Runs the entry order operand A -> operand B -> sum, then issues a one-cycle start strobe to the adder datapath.
- Also drives the BCD buffer to the display path.

Parameters:
- MAX_DIGITS, 3, max decimal digits per operand (>=1).
- DATA_W, 10, binary operand width; conversion result is taken mod 2^DATA_W if 10^MAX_DIGITS-1 does not fit.

Ports:
- clk  in  1  system clock (27 MHz).
- rst  in  1  reset; synchronous, active-low (rst==0 resets on a clk rising edge).
- key_valid  in  1  level, high while the scanner reports a pressed key.
- key_code  in  4  scanner key code; sampled only on an accepted press.
- op_a  out  DATA_W  converted operand A.
- op_b  out  DATA_W  converted operand B.
- add_start  out  1  one-cycle strobe; op_a/op_b are valid in the same cycle.
- entry_bcd  out  4*MAX_DIGITS  digit buffer, least-significant digit in [3:0].
- entry_count  out  $clog2(MAX_DIGITS+1)  number of digits in the buffer.
- state  out  3  ENTRY_A=0, CONV_A=1, ENTRY_B=2, CONV_B=3, DONE=4.

Behaviour:
- Reset: all outputs 0, state=ENTRY_A, key_prev=0, conversion accumulator and index 0.
- Press acceptance:
  - A press is accepted in a cycle where key_valid=1 and the registered key_prev=0; key_prev tracks key_valid every cycle.
  - Holding key_valid high yields exactly one press; release is required before the next press.
  - An accepted press in cycle t takes effect at the t+1 edge.
- Key map: 0x0-0x9 = digit; 0xA = next/equal; 0xC = clear; all other codes are ignored.
- ENTRY_A / ENTRY_B:
  - Digit with count<MAX_DIGITS: entry_bcd <= {entry_bcd shifted left 4, digit}, count+1. Leading zeros count as digits.
  - Digit with count==MAX_DIGITS: ignored; buffer unchanged.
  - 0xA: go to CONV_A / CONV_B, including when count==0, which yields operand 0.
- CONV_x:
  - Lasts exactly MAX_DIGITS cycles. Each cycle: acc <= acc*10 + digit[i], where *10 is (acc<<3)+(acc<<1) and i runs from MAX_DIGITS-1 down to 0.
  - Unfilled high digits are 0, so the result is independent of count.
  - On the last conversion cycle's edge: load op_x, clear entry_bcd/count/acc, then advance. CONV_A goes to ENTRY_B. CONV_B goes to DONE and drives add_start=1 for exactly that next cycle.
  - Timing: 0xA accepted in cycle k -> CONV in cycles k+1..k+MAX_DIGITS -> op_x updated and next state visible in cycle k+MAX_DIGITS+1.
  - All presses during CONV are consumed and ignored.
- DONE:
  - op_a/op_b hold their values.
  - A digit press goes to ENTRY_A with the buffer holding that digit (count=1); op_a/op_b keep their old values until reconverted.
  - 0xA is ignored.
- Clear (0xC), in any state including CONV:
  - Next edge: state=ENTRY_A; entry_bcd, count, acc, op_a, op_b all cleared.
  - add_start=0; a strobe already scheduled is not issued.
- Reset mid-operation, in any state: the same result as power-on reset at the next edge.
- add_start never asserts in two consecutive cycles.

Optional Feature:
- Macro: KEYPAD_BACKSPACE_EN.
- Defined: key 0xD in ENTRY_A/B with count>0 shifts entry_bcd right 4 (high digit becomes 0) and decrements count. With count==0, or in any other state, 0xD is ignored.
- Undefined: 0xD is an ignored code, and no backspace logic is synthesized.

Test Plan:
- Press 1,2,3,A,4,5,A (each press 3 cycles high, 2 low) -> op_a=123, op_b=45, exactly one add_start pulse, issued MAX_DIGITS+1 cycles after the second 0xA press; state=4 in that cycle.
- Press 9,8,7,6 in ENTRY_A -> entry_bcd=0x987, entry_count=3; then 0xA -> op_a=987.
- key_valid held high 50 cycles with code 0x7 -> entry_bcd=0x007, count=1 (single press).
- Enter A=12, press 3, then 0xC while in ENTRY_B -> state=0, op_a=0, entry_count=0, no add_start; then 5,A -> op_a=5.
- rst=0 for one cycle during CONV_B of 99+1 -> all outputs 0, state=0, add_start never asserts; re-entry 0,A,0,A -> op_a=0, op_b=0, add_start pulses once.
- (KEYPAD_BACKSPACE_EN) Press 4,5,D,6,A -> op_a=46; press D with count 0 -> no change.
